// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command becomes one SETUP/ACCESS transfer, and the result is returned on a valid/ready response.
// Optional ACCESS-phase timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_cmd_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [31:0]       pwdata_q;
    logic              psel_q;
    logic              penable_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_q;
    logic        rsp_timeout_q;
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Gated by the reset pin so the channel reads not-ready while reset is held.
    assign cmd_ready = PRESETN && (state_q == IDLE);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_q        <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr_q  <= cmd_addr;
                        pwrite_q <= cmd_write;
                        pwdata_q <= cmd_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_q    <= '0;
`endif
                end
                ACCESS: begin
                    // PREADY is checked first so it beats a same-cycle timeout.
                    if (PREADY) begin
                        rsp_rdata_q <= pwrite_q ? 32'h0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
                    end else if (wait_q == TO_LIMIT) begin
                        rsp_rdata_q   <= 32'h0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        wait_q <= wait_q + 16'd1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB3 initiator that converts single-word commands from a valid/ready command channel into APB SETUP/ACCESS transfers and returns the read data and status on a valid/ready response channel. It is the requester-side counterpart of the cape register slaves (control/status banks, pad blocks). It sits between a fabric-side sequencer or bridge and the cape APB bus, and drives PSEL/PENABLE directly. It handles one outstanding transfer at a time.

## Interface
Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait cycles with PREADY low before abort; range 1..65535.

Ports:
- PCLK  in  1  sole clock; all logic on rising edge.
- PRESETN  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  32  read data; 0 for writes and aborted transfers.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error, sampled only with PREADY in ACCESS.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register addr/write/wdata onto PADDR/PWRITE/PWDATA and go to SETUP. cmd_ready=0 in all other states.
- SETUP: PSEL=1, PENABLE=0. Always go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. On PREADY=1, capture rsp_rdata=PRDATA (read) or 0 (write) and rsp_err=PSLVERR, with rsp_timeout=0. Then drop PSEL/PENABLE and go to RESP. On PREADY=0, stay in ACCESS.
- RESP: rsp_valid=1. rsp_rdata, rsp_err and rsp_timeout are held stable until rsp_ready. Then go to IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the final ACCESS cycle. They hold their last value in IDLE and RESP.
- Wait counter: 16 bits. Cleared on entry to ACCESS; increments on each ACCESS cycle with PREADY=0.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first IDLE cycle after release. All other outputs are 0.
- Command accepted at edge 0. SETUP is cycle 1, ACCESS is cycle 2. With PREADY=1 in cycle 2, rsp_valid is high in cycle 3.
- Each PREADY-low cycle adds one cycle.
- Minimum spacing is 4 cycles per transfer: RESP to IDLE takes 1 cycle, and there is no command bypass.
- Simultaneous PREADY=1 and wait counter reaching its limit: PREADY wins, giving a normal completion.
- PRESETN asserted mid-transfer: PSEL and PENABLE drop asynchronously and the FSM returns to IDLE. No response is issued.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - In ACCESS, when the wait counter equals TIMEOUT_CYCLES and PREADY=0, abort the transfer.
  - The abort drops PSEL/PENABLE and goes to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter is built and ACCESS waits indefinitely.
  - rsp_timeout is tied to 0.

## Test plan
- Write of addr 0x0000_0010, data 0xA5A5_1234, with PREADY=1 -> PSEL rises cycle 1, PENABLE cycle 2, PWDATA=0xA5A5_1234. rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read of 0x0000_0014, slave returns 0xDEAD_BEEF after 3 PREADY-low cycles -> ACCESS lasts 4 cycles and PADDR is stable throughout. rsp_rdata=0xDEAD_BEEF.
- Read with PSLVERR=1 and PREADY=1 -> rsp_err=1, rsp_timeout=0.
- rsp_ready held low for 5 cycles -> response stays stable and cmd_ready stays 0. A queued cmd_valid is accepted only in the first IDLE cycle after the handshake.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY held low:
  - Abort after 4 wait cycles, with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The same test with the macro undefined -> no response after 100 cycles.
- PRESETN pulsed low during ACCESS -> PSEL=PENABLE=0 immediately, no rsp_valid, and the next command completes normally.
